hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, load-use stall cycles per hazard, legal 1..4.
REQ-003 Parameter TIMEOUT, default 255, maximum consecutive memory-wait cycles before error, legal 1..65535.
REQ-004 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 rs1_i, rs2_i  in  ADDR_W  ID-stage source register addresses.
REQ-008 rs1_used_i, rs2_used_i  in  1  ID instruction actually reads rs1 / rs2.
REQ-009 ex_rd_i  in  ADDR_W  EX-stage destination register.
REQ-010 ex_memread_i  in  1  EX-stage instruction is a load.
REQ-011 branch_taken_i  in  1  branch resolved taken in ID this cycle.
REQ-012 mem_req_i, mem_ready_i  in  1  data-memory request active / request completing this cycle.
REQ-013 stall_o  out  1  hold IF/ID register.
REQ-014 pc_write_o  out  1  PC update enable.
REQ-015 noop_o  out  1  insert bubble into ID/EX.
REQ-016 flush_o  out  1  flush IF/ID (taken branch).
REQ-017 freeze_o  out  1  hold every pipeline register (memory wait).
REQ-018 err_o  out  1  sticky memory-timeout error.
REQ-019 stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-020 Load-use hazard (lu) SHALL be: ex_memread_i, ex_rd_i nonzero, and (rs1_used_i with rs1_i==ex_rd_i, or rs2_used_i with rs2_i==ex_rd_i); a zero or unused source never matches.
REQ-021 Memory wait (mw) SHALL be mem_req_i and not mem_ready_i.
REQ-022 FSM states SHALL be RUN, LU_STALL, ERR.
REQ-023 RUN, mw: freeze_o=1, stall_o=1, pc_write_o=0, noop_o=0, flush_o=0; state and stall counter held.
REQ-024 RUN, no mw, lu: stall_o=1, noop_o=1, pc_write_o=0 in the same cycle (zero latency); if LOAD_LAT>1, go to LU_STALL with remaining count LOAD_LAT-1.
REQ-025 LU_STALL: stall_o=1, noop_o=1, pc_write_o=0; remaining count decrements each non-mw cycle; exit to RUN on the cycle the count reaches 0, giving exactly LOAD_LAT stall cycles per hazard.
REQ-026 LU_STALL, mw: freeze_o=1 added; remaining count held; noop_o=0.
REQ-027 flush_o SHALL equal branch_taken_i gated by not stall_o and not freeze_o; a taken branch coincident with a stall is not flushed that cycle (re-resolved after the stall).
REQ-028 Default (RUN, no mw, no lu): stall_o=0, noop_o=0, freeze_o=0, pc_write_o=1.
REQ-029 Wait counter: increments each consecutive mw cycle, clears on any non-mw cycle; when it reaches TIMEOUT with mw still asserted, go to ERR next edge.
REQ-030 ERR: err_o=1, freeze_o=1, stall_o=1, pc_write_o=0, noop_o=0, flush_o=0; exit only by reset.
REQ-031 stall_cnt_o increments once per cycle with noop_o=1; saturates at all-ones, no wrap.

Reset
REQ-032 rst_i high SHALL asynchronously force state RUN, remaining count 0, wait counter 0, err_o=0, stall_cnt_o=0.
REQ-033 While rst_i is high, stall_o, noop_o, flush_o, freeze_o SHALL be 0 and pc_write_o 1.
REQ-034 Reset asserted mid-LU_STALL or mid-wait SHALL abandon the stall; no residual stall after deassertion.

Structure
REQ-035 State encodings and the LOAD_LAT/TIMEOUT legal-range checks SHALL live in shared header hazard_pkg.
REQ-036 One sub-module hazard_cmp SHALL compute per-source match (addr, used, ex_rd), instantiated twice.
REQ-037 Remaining-count width SHALL be 2 bits; wait counter width SHALL be clog2(TIMEOUT+1).

Verification
REQ-038 LOAD_LAT=1, rs1=5 used, ex_rd=5, memread=1 one cycle -> stall/noop=1, pc_write=0 for exactly 1 cycle, stall_cnt_o=1.
REQ-039 rs2=0 used, ex_rd=0, memread=1 -> no stall; rs1=3 unused, ex_rd=3 -> no stall.
REQ-040 LOAD_LAT=3, hazard, then mw for 2 cycles in second stall cycle -> freeze_o 2 cycles, total noop cycles 3, stall_cnt_o=3.
REQ-041 branch_taken=1 coincident with hazard -> flush_o=0; next cycle branch_taken=1, no hazard -> flush_o=1.
REQ-042 TIMEOUT=4, mem_req=1, mem_ready=0 held -> err_o=1 after 4 wait cycles, remains 1 until rst_i; rst_i pulse -> all outputs at reset values.
REQ-043 stall_cnt_o preloaded near max via CNT_W=2 and 5 hazards -> stays 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// counter widths and the legal parameter ranges.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam int unsigned REM_W        = 2;
  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 4;
  localparam int unsigned TIMEOUT_MIN  = 1;
  localparam int unsigned TIMEOUT_MAX  = 65535;

  function automatic bit load_lat_ok(input int unsigned v);
    return (v >= LOAD_LAT_MIN) && (v <= LOAD_LAT_MAX);
  endfunction

  function automatic bit timeout_ok(input int unsigned v);
    return (v >= TIMEOUT_MIN) && (v <= TIMEOUT_MAX);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: ID/EX register info and memory handshake in,
// pipeline control and statistics out.
interface hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] rs1_i;
  logic [ADDR_W-1:0] rs2_i;
  logic              rs1_used_i;
  logic              rs2_used_i;
  logic [ADDR_W-1:0] ex_rd_i;
  logic              ex_memread_i;
  logic              branch_taken_i;
  logic              mem_req_i;
  logic              mem_ready_i;
  logic              stall_o;
  logic              pc_write_o;
  logic              noop_o;
  logic              flush_o;
  logic              freeze_o;
  logic              err_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output rs1_i, rs2_i, rs1_used_i, rs2_used_i, ex_rd_i, ex_memread_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    input  stall_o, pc_write_o, noop_o, flush_o, freeze_o, err_o, stall_cnt_o
  );

  modport slave (
    input  rs1_i, rs2_i, rs1_used_i, rs2_used_i, ex_rd_i, ex_memread_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    output stall_o, pc_write_o, noop_o, flush_o, freeze_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_cmp.sv
// Per-source load-use match: a used, nonzero source equal to the EX destination.
module hazard_cmp #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              used_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  output logic              match_o
);

  assign match_o = used_i && (ex_rd_i != '0) && (addr_i == ex_rd_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait freeze with
// timeout error, branch flush and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  if (!load_lat_ok(LOAD_LAT)) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT must be 1..4");
  end
  if (!timeout_ok(TIMEOUT)) begin : g_bad_timeout
    $error("hazard_ctrl: TIMEOUT must be 1..65535");
  end

  state_e             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic rs1_hit, rs2_hit, lu, mw, timeout;
  logic stall, pc_write, noop, flush, freeze, err;

  hazard_cmp #(.ADDR_W(ADDR_W)) u_cmp_rs1 (
    .addr_i  (bus.rs1_i),
    .used_i  (bus.rs1_used_i),
    .ex_rd_i (bus.ex_rd_i),
    .match_o (rs1_hit)
  );

  hazard_cmp #(.ADDR_W(ADDR_W)) u_cmp_rs2 (
    .addr_i  (bus.rs2_i),
    .used_i  (bus.rs2_used_i),
    .ex_rd_i (bus.ex_rd_i),
    .match_o (rs2_hit)
  );

  assign lu = bus.ex_memread_i && (rs1_hit || rs2_hit);
  assign mw = bus.mem_req_i && !bus.mem_ready_i;

  // Timeout fires on the edge that would bring the wait count to TIMEOUT.
  always_comb begin
    wait_d  = '0;
    timeout = 1'b0;
    if (mw) begin
      timeout = (wait_q == WAIT_W'(TIMEOUT - 1));
      wait_d  = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stall    = 1'b0;
    pc_write = 1'b1;
    noop     = 1'b0;
    freeze   = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mw) begin
          stall    = 1'b1;
          freeze   = 1'b1;
          pc_write = 1'b0;
        end else if (lu) begin
          stall    = 1'b1;
          noop     = 1'b1;
          pc_write = 1'b0;
          if (LOAD_LAT > 1) begin
            state_d = LU_STALL;
            rem_d   = REM_W'(LOAD_LAT - 1);
          end
        end
      end
      LU_STALL: begin
        stall    = 1'b1;
        pc_write = 1'b0;
        if (mw) begin
          freeze = 1'b1;
        end else begin
          noop  = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) state_d = RUN;
        end
      end
      ERR: begin
        stall    = 1'b1;
        freeze   = 1'b1;
        pc_write = 1'b0;
        err      = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (timeout) state_d = ERR;
    // Registers are already cleared asynchronously; this masks the
    // combinational outputs while reset is held.
    if (rst_i) begin
      stall    = 1'b0;
      pc_write = 1'b1;
      noop     = 1'b0;
      freeze   = 1'b0;
      err      = 1'b0;
    end
  end

  assign flush = bus.branch_taken_i && !stall && !freeze && !rst_i;
  assign cnt_d = (noop && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      rem_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.pc_write_o  = pc_write;
  assign bus.noop_o      = noop;
  assign bus.flush_o     = flush;
  assign bus.freeze_o    = freeze;
  assign bus.err_o       = err;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: instance A (LOAD_LAT=1, TIMEOUT=4, CNT_W=2)
// and instance B (LOAD_LAT=3, defaults otherwise) share clock and reset.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] exrd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        pcw;
    logic        noop;
    logic        flush;
    logic        freeze;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    int    sel;
    exp_t  e;
    string nm;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_W(5), .CNT_W(2))  bus_a ();
  hazard_ctrl_if #(.ADDR_W(5), .CNT_W(16)) bus_b ();

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .TIMEOUT(4), .CNT_W(2)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .TIMEOUT(255), .CNT_W(16)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  function automatic in_t hz(input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] exrd, input logic mr,
                             input logic br, input logic req, input logic rdy);
    in_t v;
    v.rst = 1'b0; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.exrd = exrd; v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  function automatic exp_t ex(input logic stall, input logic pcw, input logic noop,
                              input logic flush, input logic freeze, input logic err,
                              input int cnt);
    exp_t e;
    e.stall = stall; e.pcw = pcw; e.noop = noop; e.flush = flush;
    e.freeze = freeze; e.err = err; e.cnt = 16'(cnt);
    return e;
  endfunction

  function automatic exp_t n_(input int cnt); return ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt); endfunction
  function automatic exp_t s_(input int cnt); return ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt); endfunction
  function automatic exp_t f_(input int cnt); return ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cnt); endfunction
  function automatic exp_t e_(input int cnt); return ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cnt); endfunction
  function automatic exp_t fl(input int cnt); return ex(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cnt); endfunction

  task automatic set_a(input in_t v);
    bus_a.rs1_i = v.rs1; bus_a.rs1_used_i = v.u1; bus_a.rs2_i = v.rs2; bus_a.rs2_used_i = v.u2;
    bus_a.ex_rd_i = v.exrd; bus_a.ex_memread_i = v.mr; bus_a.branch_taken_i = v.br;
    bus_a.mem_req_i = v.req; bus_a.mem_ready_i = v.rdy;
  endtask

  task automatic set_b(input in_t v);
    bus_b.rs1_i = v.rs1; bus_b.rs1_used_i = v.u1; bus_b.rs2_i = v.rs2; bus_b.rs2_used_i = v.u2;
    bus_b.ex_rd_i = v.exrd; bus_b.ex_memread_i = v.mr; bus_b.branch_taken_i = v.br;
    bus_b.mem_req_i = v.req; bus_b.mem_ready_i = v.rdy;
  endtask

  task automatic step(input int sel, input in_t v, input exp_t e, input string nm);
    ent_t t;
    @(posedge clk);
    #1;
    rst = v.rst;
    if (sel == 0) begin set_a(v); set_b('0); end
    else          begin set_a('0); set_b(v); end
    t.sel = sel; t.e = e; t.nm = nm;
    q.push_back(t);
  endtask

  exp_t got;
  ent_t cur;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      if (cur.sel == 0)
        got = ex(bus_a.stall_o, bus_a.pc_write_o, bus_a.noop_o, bus_a.flush_o,
                 bus_a.freeze_o, bus_a.err_o, int'(bus_a.stall_cnt_o));
      else
        got = ex(bus_b.stall_o, bus_b.pc_write_o, bus_b.noop_o, bus_b.flush_o,
                 bus_b.freeze_o, bus_b.err_o, int'(bus_b.stall_cnt_o));
      checks++;
      if (got !== cur.e)
        $display("FAIL %s: got stall=%b pcw=%b noop=%b flush=%b freeze=%b err=%b cnt=%0d, want stall=%b pcw=%b noop=%b flush=%b freeze=%b err=%b cnt=%0d",
                 cur.nm, got.stall, got.pcw, got.noop, got.flush, got.freeze, got.err, got.cnt,
                 cur.e.stall, cur.e.pcw, cur.e.noop, cur.e.flush, cur.e.freeze, cur.e.err, cur.e.cnt);
      else
        passed++;
    end
  end

  in_t idle, hz5, rin;

  initial begin
    idle = '0;
    hz5  = hz(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    set_a('0);
    set_b('0);

    // Instance A: LOAD_LAT=1, TIMEOUT=4, CNT_W=2
    rin = hz(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    rin.rst = 1'b1;
    step(0, rin, n_(0), "a_rst_force");
    step(0, idle, n_(0), "a_idle");
    step(0, hz5, s_(0), "a_lu_rs1");
    step(0, idle, n_(1), "a_lu_end");
    step(0, hz(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), n_(1), "a_zero_src");
    step(0, hz(5'd3, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), n_(1), "a_unused_src");
    step(0, hz(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), s_(1), "a_lu_rs2");
    step(0, hz(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), s_(2), "a_br_in_stall");
    step(0, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), fl(3), "a_br_flush");
    for (int i = 0; i < 5; i++) step(0, hz5, s_(3), "a_cnt_sat");
    step(0, idle, n_(3), "a_cnt_hold");
    step(0, hz(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0), f_(3), "a_mw_run");
    step(0, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), n_(3), "a_mem_done");
    for (int i = 0; i < 4; i++)
      step(0, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), f_(3), "a_wait");
    step(0, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), e_(3), "a_timeout");
    step(0, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), e_(3), "a_err_sticky");
    rin = idle; rin.rst = 1'b1;
    step(0, rin, n_(0), "a_rst_err");
    step(0, idle, n_(0), "a_after_rst");

    // Instance B: LOAD_LAT=3
    step(1, rin, n_(0), "b_rst");
    step(1, idle, n_(0), "b_idle");
    step(1, hz5, s_(0), "b_lu_c1");
    step(1, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), f_(1), "b_mw1");
    step(1, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), f_(1), "b_mw2");
    step(1, idle, s_(1), "b_lu_c2");
    step(1, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), s_(2), "b_lu_c3");
    step(1, hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), fl(3), "b_lu_done");
    step(1, hz(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0), f_(3), "b_mw_over_lu");
    step(1, hz5, s_(3), "b_lu2_c1");
    step(1, idle, s_(4), "b_lu2_c2");
    step(1, rin, n_(0), "b_rst_mid");
    step(1, idle, n_(0), "b_no_residual");
    step(1, idle, n_(0), "b_still_run");

    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
